div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//  Sequencing controller for the calculator's power-of-two integer divide path.
//  Synchronises the divide button and turns a press into a start request.
//  Latches both operands, checks that the divisor is a legal power of two,
//  then shifts the dividend right one bit per clock. Reports busy, done and
//  error, and holds the quotient for the display/result mux. Remainder is discarded.
// PARAMETERS
//  WIDTH        9   operand/result width in bits
//  SYNC_STAGES  2   flip-flop stages on the raw button input (>=2)
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  rst_n     in   1      asynchronous active-low reset
//  but_div   in   1      raw divide button, asynchronous, press = 1->0
//  start     in   1      synchronous start pulse from calculator control
//  div1      in   WIDTH  dividend, unsigned
//  div2      in   WIDTH  divisor, unsigned
//  busy      out  1      high from accepted start until the done cycle inclusive
//  done      out  1      one-cycle pulse: res_div/err valid from this cycle on
//  err       out  1      illegal divisor flag, held until next accepted start
//  res_div   out  WIDTH  quotient floor(div1/div2), held until next done
// BEHAVIOUR
//  Clock and reset
//  - One clock. rst_n is asynchronous assert and synchronous deassert, taken from the top level.
//  - Reset values: busy=0, done=0, err=0, res_div=0, FSM=IDLE.
//  - Reset values: sync chain all 1 (button released), shift counter=0.
//  - Reset mid-operation aborts the operation. No done pulse follows. Latched operands are discarded.
//  Start request
//  - but_div passes through SYNC_STAGES flops.
//  - A falling edge on the synced signal gives a one-cycle press pulse.
//  - req = start | press. The button is not debounced here; the board debouncer sits upstream.
//  States
//  - IDLE: on req, latch div1 into acc and div2 into dsr, set busy, go to CHECK.
//  - IDLE: err clears on the same edge. res_div keeps its old value.
//  - CHECK: dsr must have exactly one bit set, in bit positions 0..7 (1,2,4,...,128).
//  - CHECK, legal divisor: k = index of that bit, load cnt=k. k=0 goes to DONE, otherwise SHIFT.
//  - CHECK, illegal divisor (0, 256, non-power-of-two): go to ERR.
//  - SHIFT: acc <= acc >> 1 (logical, zero fill), cnt <= cnt-1. At cnt==1 go to DONE.
//  - DONE: res_div <= acc, done=1 for this cycle. Next state is IDLE; busy drops on the following cycle.
//  - ERR: res_div <= 0, err <= 1, done=1 for this cycle. Next state is IDLE.
//  Timing (start sampled at edge E0)
//  - done is high in cycle E0+2+k. Error result: done is high in cycle E0+2.
//  - For button starts, add SYNC_STAGES+1 cycles from the pin edge.
//  Boundary rules
//  - req while busy is ignored; it is not queued. Operand inputs are don't-care while busy.
//  - req in the DONE/ERR cycle is ignored (busy is still high).
//  - req in the first IDLE cycle after DONE/ERR is accepted.
//  - start and press in the same cycle count as one request.
//  - div1=0 is legal and gives 0. Dividend bit WIDTH-1 shifts like any other bit (unsigned).
//  - done is never high in two consecutive cycles.
//  - err and done are never asserted outside DONE/ERR.
// TESTING
//  1. start with div1=200, div2=8 -> busy=1 in cycles 1..5, done=1 in cycle 5, res_div=25, err=0.
//  2. start with div1=255, div2=1 -> done in cycle 2, res_div=255. Then 511/128 -> res_div=3, done in cycle 9.
//  3. Illegal divisors: div1=100 with div2=3, div2=0, then div2=256 -> each run: done in cycle 2, err=1, res_div=0.
//     A following legal 100/4 clears err and gives res_div=25.
//  4. start 200/64; pulse start again in cycle 3 and in the DONE cycle -> only one done, res_div=3.
//     start in the next cycle is accepted.
//  5. Drive but_div 1->0 at t=0 with 96/32 -> done SYNC_STAGES+1+7 cycles later, res_div=3.
//     Holding but_div low gives no second run.
//  6. start 400/128; assert rst_n=0 in cycle 4 -> all outputs 0 immediately, no done after release.
//     A new 400/128 run completes with res_div=3.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequencer for the power-of-two divide path: synchronises the divide button,
// validates the divisor and shifts the dividend right one bit per clock.
module div_sequencer #(
    parameter int WIDTH       = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             but_div,
    input  logic             start,
    input  logic [WIDTH-1:0] div1,
    input  logic [WIDTH-1:0] div2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] res_div
);

    localparam int CNT_W      = $clog2(WIDTH);
    // The top operand bit is excluded: a divisor of 2**(WIDTH-1) is rejected.
    localparam int LEGAL_BITS = WIDTH - 1;

    typedef enum logic [2:0] {IDLE, CHECK, SHIFT, DONE, ERR} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   syncPrev;
    logic                   pressPulse;
    logic                   req;
    logic [WIDTH-1:0]       acc;
    logic [WIDTH-1:0]       dsr;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       dsrIdx;
    logic                   dsrLegal;

    function automatic logic isLegalDivisor(input logic [WIDTH-1:0] d);
        return (d != '0) && ((d & (d - WIDTH'(1))) == '0) && !d[WIDTH-1];
    endfunction

    function automatic logic [CNT_W-1:0] bitIndex(input logic [WIDTH-1:0] d);
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < LEGAL_BITS; i++) begin
            if (d[i]) idx = CNT_W'(i);
        end
        return idx;
    endfunction

    // Press pulse is registered so it is glitch-free and exactly one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg    <= '1;
            syncPrev   <= 1'b1;
            pressPulse <= 1'b0;
        end else begin
            syncReg    <= {syncReg[SYNC_STAGES-2:0], but_div};
            syncPrev   <= syncReg[SYNC_STAGES-1];
            pressPulse <= syncPrev & ~syncReg[SYNC_STAGES-1];
        end
    end

    assign req      = start | pressPulse;
    assign dsrLegal = isLegalDivisor(dsr);
    assign dsrIdx   = bitIndex(dsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            res_div <= '0;
            acc     <= '0;
            dsr     <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        acc   <= div1;
                        dsr   <= div2;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= dsrIdx;
                    if (!dsrLegal) begin
                        res_div <= '0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state   <= ERR;
                    end else if (dsrIdx == '0) begin
                        res_div <= acc;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc >> 1;
                    cnt <= cnt - CNT_W'(1);
                    // Last shift lands directly in the result so done and res_div align.
                    if (cnt == CNT_W'(1)) begin
                        res_div <= acc >> 1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
